// File: rtl/stopwatch_pkg.sv
// Shared stopwatch definitions: FSM state encoding, button events
// and BCD digit maxima used by both the controller and the datapath.
package stopwatch_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_LAP   = 3'd2,
        ST_PAUSE = 3'd3,
        ST_DONE  = 3'd4
    } sw_state_e;

    typedef enum logic [1:0] {
        EV_NONE,
        EV_STOP,
        EV_START,
        EV_LAP
    } sw_event_e;

    localparam int TENTHS_MAX  = 9;
    localparam int ONES_MAX    = 9;
    localparam int TENS_MAX    = 5;
    localparam int MINUTES_MAX = 9;

    // Only the highest-priority event of a cycle survives.
    function automatic sw_event_e pick_event(input logic stop,
                                             input logic start,
                                             input logic lap);
        sw_event_e ev;
        ev = EV_NONE;
        if (stop)       ev = EV_STOP;
        else if (start) ev = EV_START;
        else if (lap)   ev = EV_LAP;
        return ev;
    endfunction

endpackage

// File: rtl/stopwatch_ctrl_btn_edge.sv
// One-bit button history register with rising-edge detect.
module sw_btn_edge (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic rise
);

    logic btn_q;
    logic btn_d;

    always_comb btn_d = btn;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) btn_q <= 1'b0;
        else       btn_q <= btn_d;
    end

    assign rise = btn & ~btn_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM: button events, tenth-second prescaler,
// clear/load/lap/done sequencing for the BCD counter datapath.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       Start,
    input  logic       Stop,
    input  logic       Lap,
    input  logic       Countdown,
    input  logic       at_zero,
    input  logic       at_max,
    output logic       cnt_en,
    output logic       cnt_down,
    output logic       cnt_clear,
    output logic       cnt_load,
    output logic       lap_hold,
    output logic       running,
    output logic       done,
    output logic [2:0] state
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);

    logic start_ev, stop_ev, lap_ev;

    sw_btn_edge u_start (.clk(clk), .reset(reset), .btn(Start), .rise(start_ev));
    sw_btn_edge u_stop  (.clk(clk), .reset(reset), .btn(Stop),  .rise(stop_ev));
    sw_btn_edge u_lap   (.clk(clk), .reset(reset), .btn(Lap),   .rise(lap_ev));

    sw_state_e     state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          cnt_down_q, cnt_down_d;
    logic          cnt_en_q, cnt_en_d;
    logic          cnt_clear_q, cnt_clear_d;
    logic          cnt_load_q, cnt_load_d;
    logic          lap_hold_q, lap_hold_d;
    logic          running_q, running_d;
    logic          done_q, done_d;

    sw_event_e ev;
    logic      counting;
    logic      tick_raw;
    logic      term;

    always_comb begin
        state_d     = state_q;
        presc_d     = presc_q;
        cnt_down_d  = cnt_down_q;
        cnt_clear_d = 1'b0;
        cnt_load_d  = 1'b0;
        done_d      = 1'b0;

        ev       = pick_event(stop_ev, start_ev, lap_ev);
        counting = (state_q == ST_RUN) || (state_q == ST_LAP);
        tick_raw = counting && (presc_q == P_LAST);
        term     = cnt_down_q ? at_zero : at_max;

        // A terminal tick is swallowed so the datapath never wraps.
        cnt_en_d = tick_raw && !term;

        if (counting) presc_d = tick_raw ? '0 : presc_q + 1'b1;

        unique case (state_q)
            ST_IDLE: begin
                if (ev == EV_START) begin
                    state_d     = ST_RUN;
                    cnt_down_d  = Countdown;
                    cnt_load_d  = Countdown;
                    cnt_clear_d = ~Countdown;
                end
            end
            ST_RUN, ST_LAP: begin
                if (ev == EV_STOP) begin
                    state_d = ST_PAUSE;
                end else if (ev == EV_LAP) begin
                    state_d = (state_q == ST_RUN) ? ST_LAP : ST_RUN;
                end else if (tick_raw && term) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end
            end
            ST_PAUSE: begin
                if (ev == EV_START) begin
                    state_d = ST_RUN;
                end else if (ev == EV_STOP) begin
                    state_d     = ST_IDLE;
                    cnt_clear_d = 1'b1;
                    presc_d     = '0;
                    cnt_down_d  = 1'b0;
                end
            end
            ST_DONE: begin
                if ((ev == EV_STOP) || (ev == EV_START)) begin
                    state_d     = ST_IDLE;
                    cnt_clear_d = 1'b1;
                    presc_d     = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                presc_d = '0;
            end
        endcase

        lap_hold_d = (state_d == ST_LAP);
        running_d  = (state_d == ST_RUN) || (state_d == ST_LAP);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            presc_q     <= '0;
            cnt_down_q  <= 1'b0;
            cnt_en_q    <= 1'b0;
            cnt_clear_q <= 1'b0;
            cnt_load_q  <= 1'b0;
            lap_hold_q  <= 1'b0;
            running_q   <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            presc_q     <= presc_d;
            cnt_down_q  <= cnt_down_d;
            cnt_en_q    <= cnt_en_d;
            cnt_clear_q <= cnt_clear_d;
            cnt_load_q  <= cnt_load_d;
            lap_hold_q  <= lap_hold_d;
            running_q   <= running_d;
            done_q      <= done_d;
        end
    end

    assign cnt_en    = cnt_en_q;
    assign cnt_down  = cnt_down_q;
    assign cnt_clear = cnt_clear_q;
    assign cnt_load  = cnt_load_q;
    assign lap_hold  = lap_hold_q;
    assign running   = running_q;
    assign done      = done_q;
    assign state     = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: directed scenarios with literal expectations,
// then random buttons/flags against an integer-level reference model.
module tb_stopwatch_ctrl;

    localparam int TD = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0, stop = 1'b0, lap = 1'b0;
    logic       cd = 1'b0, az = 1'b0, am = 1'b0;
    logic       cnt_en, cnt_down, cnt_clear, cnt_load;
    logic       lap_hold, running, done;
    logic [2:0] state;

    int checks = 0;
    int failures = 0;

    stopwatch_ctrl #(.TICK_DIV(TD)) dut (
        .clk(clk), .reset(reset),
        .Start(start), .Stop(stop), .Lap(lap),
        .Countdown(cd), .at_zero(az), .at_max(am),
        .cnt_en(cnt_en), .cnt_down(cnt_down),
        .cnt_clear(cnt_clear), .cnt_load(cnt_load),
        .lap_hold(lap_hold), .running(running),
        .done(done), .state(state)
    );

    always #5 clk = ~clk;

    // Mode numbers: 0 idle, 1 run, 2 lap, 3 pause, 4 done.
    typedef struct packed {
        int st;
        int p;
        bit down, en, clr, ld, dn, hold, run;
        bit ps, pt, pl;
    } mdl_t;

    mdl_t m;

    function automatic mdl_t mstep(input mdl_t c, input logic s,
                                   input logic t, input logic l,
                                   input logic dir, input logic z,
                                   input logic mx);
        mdl_t n;
        int   ev;
        bit   moving, tick, term;
        n = c;
        n.ps = s; n.pt = t; n.pl = l;
        if (t && !c.pt)      ev = 1;
        else if (s && !c.ps) ev = 2;
        else if (l && !c.pl) ev = 3;
        else                 ev = 0;
        moving = (c.st == 1) || (c.st == 2);
        tick = moving && (c.p == TD - 1);
        term = c.down ? z : mx;
        n.en = tick && !term;
        n.clr = 0; n.ld = 0; n.dn = 0;
        if (moving) n.p = (c.p + 1) % TD;
        if (c.st == 0 && ev == 2) begin
            n.st = 1; n.down = dir; n.ld = dir; n.clr = !dir;
        end else if (moving) begin
            if (ev == 1)           n.st = 3;
            else if (ev == 3)      n.st = 3 - c.st;
            else if (tick && term) begin n.st = 4; n.dn = 1; end
        end else if (c.st == 3) begin
            if (ev == 2) n.st = 1;
            else if (ev == 1) begin
                n.st = 0; n.clr = 1; n.p = 0; n.down = 0;
            end
        end else if (c.st == 4 && (ev == 1 || ev == 2)) begin
            n.st = 0; n.clr = 1; n.p = 0;
        end
        n.hold = (n.st == 2);
        n.run = (n.st == 1) || (n.st == 2);
        return n;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) m <= '0;
        else       m <= mstep(m, start, stop, lap, cd, az, am);
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0d expected %0d",
                     nm, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        chk("m_state", 32'(state), 32'(m.st));
        chk("m_cnt_en", 32'(cnt_en), 32'(m.en));
        chk("m_cnt_down", 32'(cnt_down), 32'(m.down));
        chk("m_cnt_clear", 32'(cnt_clear), 32'(m.clr));
        chk("m_cnt_load", 32'(cnt_load), 32'(m.ld));
        chk("m_lap_hold", 32'(lap_hold), 32'(m.hold));
        chk("m_running", 32'(running), 32'(m.run));
        chk("m_done", 32'(done), 32'(m.dn));
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        step(2);
        chk("rst_state", 32'(state), 0);
        chk("rst_running", 32'(running), 0);
        chk("rst_cnt_down", 32'(cnt_down), 0);
        reset = 1'b0;
        step(1);

        // Count-up start, tick every 4th cycle, held Stop.
        start = 1; step(1);
        chk("s1_clear", 32'(cnt_clear), 1);
        chk("s1_running", 32'(running), 1);
        start = 0; step(3);
        chk("s1_clear_gone", 32'(cnt_clear), 0);
        chk("s1_no_tick", 32'(cnt_en), 0);
        step(1);
        chk("s1_tick", 32'(cnt_en), 1);
        step(1);
        chk("s1_tick_once", 32'(cnt_en), 0);
        stop = 1;
        for (int i = 0; i < 10; i++) begin
            step(1);
            chk("s1_pause_held", 32'(state), 3);
        end
        stop = 0; step(1);

        // Partial tenth survives a pause.
        stop = 1; step(1);
        chk("s2_idle", 32'(state), 0);
        chk("s2_clear", 32'(cnt_clear), 1);
        stop = 0; start = 1; step(1);
        start = 0; step(5);
        stop = 1; step(1);
        chk("s2_pause", 32'(state), 3);
        stop = 0; step(20);
        start = 1; step(1);
        chk("s2_resume", 32'(state), 1);
        start = 0; step(1);
        chk("s2_no_tick_yet", 32'(cnt_en), 0);
        step(1);
        chk("s2_tick_2_after", 32'(cnt_en), 1);

        // Lap freeze while counting continues.
        lap = 1; step(1);
        chk("s3_lap_state", 32'(state), 2);
        chk("s3_hold", 32'(lap_hold), 1);
        lap = 0; step(3);
        chk("s3_tick_in_lap", 32'(cnt_en), 1);
        chk("s3_hold_kept", 32'(lap_hold), 1);
        lap = 1; step(1);
        chk("s3_back_run", 32'(state), 1);
        chk("s3_unhold", 32'(lap_hold), 0);
        lap = 0;

        // Countdown to zero.
        stop = 1; step(1);
        stop = 0; step(1);
        stop = 1; step(1);
        chk("s4_idle", 32'(state), 0);
        stop = 0; cd = 1; start = 1; step(1);
        chk("s4_load", 32'(cnt_load), 1);
        chk("s4_no_clear", 32'(cnt_clear), 0);
        chk("s4_down", 32'(cnt_down), 1);
        start = 0; az = 1; step(3);
        chk("s4_still_run", 32'(state), 1);
        step(1);
        chk("s4_done_state", 32'(state), 4);
        chk("s4_done", 32'(done), 1);
        chk("s4_no_en", 32'(cnt_en), 0);
        step(1);
        chk("s4_done_once", 32'(done), 0);
        az = 0; start = 1; step(1);
        chk("s4_exit_idle", 32'(state), 0);
        chk("s4_exit_clear", 32'(cnt_clear), 1);
        start = 0; cd = 0; step(1);

        // Simultaneous Start and Stop in PAUSE.
        start = 1; step(1);
        start = 0; stop = 1; step(1);
        stop = 0; step(1);
        start = 1; stop = 1; step(1);
        chk("s5_idle", 32'(state), 0);
        chk("s5_clear", 32'(cnt_clear), 1);
        start = 0; stop = 0; step(1);
        start = 1; step(1);
        start = 0; step(3);
        chk("s5_presc_zero_a", 32'(cnt_en), 0);
        step(1);
        chk("s5_presc_zero_b", 32'(cnt_en), 1);

        // Asynchronous reset in LAP with prescaler at 3.
        lap = 1; step(1);
        lap = 0; step(2);
        #2 reset = 1;
        #1;
        chk("s6_state", 32'(state), 0);
        chk("s6_hold", 32'(lap_hold), 0);
        chk("s6_running", 32'(running), 0);
        chk("s6_en", 32'(cnt_en), 0);
        step(1);
        reset = 0;
        for (int i = 0; i < 5; i++) begin
            step(1);
            chk("s6_quiet", 32'({cnt_en, done}), 0);
        end

        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 3) == 0) start = ~start;
            if ($urandom_range(0, 5) == 0) stop = ~stop;
            if ($urandom_range(0, 4) == 0) lap = ~lap;
            if ($urandom_range(0, 19) == 0) cd = ~cd;
            az = ($urandom_range(0, 15) == 0);
            am = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 599) == 0) begin
                #2 reset = 1;
                @(negedge clk);
                reset = 0;
            end
        end

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
Control FSM that sequences the BCD stopwatch counter datapath (tenths/ones/tens/minutes).
- Converts the Start/Stop/Lap buttons into single-cycle events.
- Generates the tenth-second count-enable tick and fixes the count direction.
- Issues clear/load pulses and a lap display-freeze.
- Sits between the button inputs and the counter/display registers.

Parameters:
TICK_DIV, 10, clock cycles per tenth-second tick (legal values >= 1; 1 = tick every cycle while counting)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
Start  in  1  start/resume button, synchronous level
Stop  in  1  pause/clear button, synchronous level
Lap  in  1  lap-freeze toggle button, synchronous level
Countdown  in  1  mode select: 1 = count down from preset, 0 = count up
at_zero  in  1  datapath flag: all digits 0
at_max  in  1  datapath flag: 9:59.9
cnt_en  out  1  one-cycle tick: datapath steps one tenth
cnt_down  out  1  direction for datapath (1 = decrement)
cnt_clear  out  1  one-cycle pulse: datapath clears to 0:00.0
cnt_load  out  1  one-cycle pulse: datapath loads countdown preset
lap_hold  out  1  display registers freeze while 1
running  out  1  1 in RUN or LAP
done  out  1  one-cycle pulse on reaching terminal count
state  out  3  current FSM state encoding (debug)

Behaviour:
- Reset (async, active-high):
  - State = IDLE; prescaler = 0; button history registers = 0.
  - All outputs 0: cnt_down=0, lap_hold=0, running=0.
- Edge detect:
  - Each event is button & ~button_q, with button_q registered each cycle.
  - A held button produces exactly one event.
  - Simultaneous events: priority Stop > Start > Lap; lower-priority events that cycle are discarded.
- Timing: an event sampled at edge N changes state at edge N. The new state and outputs are visible after edge N. All outputs are registered.
- States: IDLE, RUN, LAP, PAUSE, DONE.
  - IDLE:
    - On Start: latch cnt_down <= Countdown, then go to RUN.
    - If Countdown=1, also pulse cnt_load. Otherwise pulse cnt_clear.
    - Stop and Lap are ignored.
  - RUN:
    - Stop -> PAUSE.
    - Lap -> LAP, with lap_hold=1.
  - LAP:
    - Counting continues.
    - Lap -> RUN, with lap_hold=0.
    - Stop -> PAUSE, with lap_hold=0.
  - PAUSE:
    - Prescaler holds its value, so the partial tenth is preserved.
    - Start -> RUN.
    - Stop -> IDLE, pulse cnt_clear, prescaler=0, cnt_down=0.
  - DONE:
    - Start or Stop -> IDLE, pulse cnt_clear, prescaler=0.
    - Lap is ignored.
- cnt_down changes only on the IDLE->RUN transition. Countdown toggles in other states are ignored.
- Prescaler and tick:
  - The prescaler counts 0..TICK_DIV-1 only in RUN/LAP; tick_raw = (prescaler == TICK_DIV-1).
  - term = cnt_down ? at_zero : at_max.
  - On tick_raw with term=0: register cnt_en=1 for one cycle.
  - On tick_raw with term=1: cnt_en stays 0, state goes to DONE, done pulses for one cycle, lap_hold clears.
  - Net effect: the datapath never wraps below 0:00.0 or above 9:59.9.
- A Stop/Start/Lap event in the same cycle as tick_raw:
  - The event transition wins.
  - The tick is still issued if leaving RUN/LAP for PAUSE. PAUSE takes that final tenth.
- Reset mid-operation returns to IDLE immediately; no pulses are emitted.
- Prescaler width is $clog2(TICK_DIV), minimum 1 bit.

Decomposition:
- Package stopwatch_pkg holds:
  - State encoding constants: IDLE=0, RUN=1, LAP=2, PAUSE=3, DONE=4.
  - Digit maxima constants (9/5/9 per digit) for shared use with the datapath.
- One natural sub-module: sw_btn_edge, a 1-bit register plus rising-edge detect, instantiated three times.
- FSM and prescaler live in stopwatch_ctrl.

Test Plan:
All scenarios use TICK_DIV=4.
1. Reset, then Start pulse with Countdown=0 -> cnt_clear for 1 cycle, running=1, cnt_en every 4th cycle; 10 cycles of Stop high -> exactly one PAUSE entry.
2. RUN for 6 cycles (prescaler=2), Stop, wait 20 cycles, Start -> first cnt_en exactly 2 cycles after resume.
3. RUN, Lap pulse -> lap_hold=1 while cnt_en continues; second Lap -> lap_hold=0, state=RUN.
4. Countdown=1, Start -> cnt_load pulse, cnt_down=1; force at_zero=1 -> on next tick_raw cnt_en=0, done=1 for one cycle, state=DONE; Start -> IDLE with cnt_clear.
5. Start and Stop rise in the same cycle while in PAUSE -> Stop wins: IDLE, cnt_clear, prescaler=0.
6. Assert reset during LAP with prescaler=3 -> all outputs 0, state=IDLE immediately (asynchronously); no done or cnt_en glitch after release.
